noc_inject_arb: RTL
===================

# noc_inject_arb

Packet-granular round-robin arbiter sharing one NoC injection port among NREQ traffic-generator AXI-Stream masters. Grants one requester at a time, holds the grant until that requester's TLAST beat is accepted, then rotates. Stamps the winning requester index on TID. Output is a single registered beat stage feeding the router's local input port.

## Interface
- NREQ, 4: number of requester streams, 2..8.
- TDATAW, 32: data width.
- TDESTW, 4: destination width.
- TIDW, 2: ID width; must satisfy 2**TIDW >= NREQ.
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- AXIS_S_TVALID  input  NREQ  per-requester valid.
- AXIS_S_TREADY  output  NREQ  per-requester ready.
- AXIS_S_TDATA  input  NREQ*TDATAW  requester i occupies bits [i*TDATAW +: TDATAW].
- AXIS_S_TLAST  input  NREQ  per-requester end of packet.
- AXIS_S_TDEST  input  NREQ*TDESTW  requester i occupies bits [i*TDESTW +: TDESTW].
- AXIS_M_TVALID / AXIS_M_TREADY  output / input  1  injection handshake.
- AXIS_M_TDATA  output  TDATAW; AXIS_M_TLAST  output  1; AXIS_M_TDEST  output  TDESTW.
- AXIS_M_TID  output  TIDW  index of the requester that produced the beat.
- PKT_CNT  output  NREQ*16  per-requester packet count; present only with the macro below.

## Operation
- FSM states: IDLE and BUSY. Registers: grant[TIDW], last[TIDW], output beat stage.
- IDLE: if any AXIS_S_TVALID is set, pick the first valid index scanning from last+1 upward, wrapping modulo NREQ. Register it into grant and go to BUSY. With no valid input, stay in IDLE.
- BUSY: AXIS_S_TREADY[grant] = (~AXIS_M_TVALID | AXIS_M_TREADY). All other AXIS_S_TREADY bits are 0. AXIS_S_TREADY is all zeros in IDLE.
- Accepted beat: a grant-side beat is accepted when its TVALID and TREADY are both high. The beat loads into the output stage with TID = grant.
- If the accepted beat has TLAST set: last <= grant and the FSM goes to IDLE. No further beat from that requester is accepted in that packet.
- Output stage: AXIS_M_TVALID is set on load. It is cleared when AXIS_M_TREADY=1 and no new beat loads in the same cycle. Simultaneous drain and load keeps AXIS_M_TVALID high with the new beat.
- The output stage drains independently of the FSM, so IDLE arbitration overlaps the drain of the final beat.
- TVALID dropping mid-packet on the granted requester: the grant is held and the FSM waits. There is no timeout.
- Non-granted requesters are never dropped; they wait for their turn.
- Reset, including mid-packet: FSM to IDLE, grant=0, last=NREQ-1 so port 0 has first priority. All outputs are 0 (AXIS_M_TVALID, AXIS_M_TLAST, AXIS_M_TDATA, AXIS_M_TDEST, AXIS_M_TID, AXIS_S_TREADY, PKT_CNT). A partial packet in flight is discarded.

## Timing
- Arbitration latency is 1 cycle: TVALID is seen in IDLE at edge k, AXIS_S_TREADY rises after edge k, the first beat is accepted at edge k+1, and AXIS_M_TVALID is high after edge k+1.
- Back-to-back packets: one dead cycle on the slave side between a TLAST acceptance and the next grant's first acceptance.
- Steady state: 1 beat/cycle while AXIS_M_TREADY=1.
- AXIS_S_TREADY depends combinationally on AXIS_M_TREADY. All other outputs are registered.

## Configuration
- NOC_ARB_PKT_CNT_EN defined: PKT_CNT exists. Counter i increments by 1 on each accepted TLAST beat from requester i, wraps at 16'hFFFF -> 0, and resets to 0.
- NOC_ARB_PKT_CNT_EN undefined: no PKT_CNT port and no counter logic. Arbitration behaviour is identical in both builds.

## Structure
- noc_pkg: arb_state_t enum (IDLE, BUSY) and PKT_CNT_W = 16. The same package carries the shared AXI-Stream width defaults (TDATAW, TDESTW, TIDW).
- Sub-module rr_arbiter: combinational rotating priority pick. Inputs are req[NREQ] and last; outputs are onehot/index and any_req. It is reused by the router's output arbitration.
- Top level holds the FSM, mux, output stage and optional counters.

## Test plan
- Single requester 1 sends a 3-beat packet (data 0x11, 0x22, 0x33; TLAST on 0x33), M_TREADY=1. Expect M beats 0x11/0x22/0x33 with TID=1, first M_TVALID 2 cycles after S_TVALID, TLAST only on 0x33.
- All 4 requesters continuously valid with 2-beat packets. Expect grant order 0,1,2,3,0, each packet contiguous, one slave-side dead cycle between packets.
- M_TREADY low for 5 cycles mid-packet. Expect M_TVALID and data held stable, S_TREADY[grant]=0 during the stall, no beat lost or duplicated.
- Requester 2 drops TVALID for 3 cycles mid-packet while requester 0 is valid. Expect the grant held on 2 and no beat from 0 until requester 2's TLAST.
- Assert RST mid-packet. Expect all outputs 0 immediately; after release, requesters 0 and 3 both valid results in port 0 granted first.
- With NOC_ARB_PKT_CNT_EN, send 3 packets from requester 3. Expect PKT_CNT[3*16 +: 16]=3 and the other counters 0. Preload near wrap to check 0xFFFF -> 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types and AXI-Stream width defaults used by the injection arbiter and router.
package noc_pkg;

   typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

   localparam int unsigned PKT_CNT_W   = 16;
   localparam int unsigned AXIS_TDATAW = 32;
   localparam int unsigned AXIS_TDESTW = 4;
   localparam int unsigned AXIS_TIDW   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first set req scanning upward from last+1, wrapping at
// NREQ. Shared by the injection arbiter and the router output arbitration.
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last,
   output logic [NREQ-1:0] onehot,
   output logic [IDXW-1:0] index,
   output logic            any_req
);

   localparam int unsigned SELW = $clog2(NREQ);

   int unsigned cand;
   logic        found;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      cand   = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = (32'(last) + off) % NREQ;
         if (!found && req[cand[SELW-1:0]]) begin
            found                   = 1'b1;
            onehot[cand[SELW-1:0]]  = 1'b1;
            index                   = IDXW'(cand);
         end
      end
      any_req = found;
   end

endmodule

// File: rtl/noc_inject_arb.sv
// Packet-granular round-robin arbiter onto one NoC injection port with a registered beat stage.
// Define NOC_ARB_PKT_CNT_EN to add per-requester accepted-packet counters on PKT_CNT.
module noc_inject_arb
   import noc_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned TDATAW = AXIS_TDATAW,
   parameter int unsigned TDESTW = AXIS_TDESTW,
   parameter int unsigned TIDW   = AXIS_TIDW
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NREQ-1:0]          AXIS_S_TVALID,
   output logic [NREQ-1:0]          AXIS_S_TREADY,
   input  logic [NREQ*TDATAW-1:0]   AXIS_S_TDATA,
   input  logic [NREQ-1:0]          AXIS_S_TLAST,
   input  logic [NREQ*TDESTW-1:0]   AXIS_S_TDEST,
   output logic                     AXIS_M_TVALID,
   input  logic                     AXIS_M_TREADY,
   output logic [TDATAW-1:0]        AXIS_M_TDATA,
   output logic                     AXIS_M_TLAST,
   output logic [TDESTW-1:0]        AXIS_M_TDEST,
   output logic [TIDW-1:0]          AXIS_M_TID
`ifdef NOC_ARB_PKT_CNT_EN
   ,
   output logic [NREQ*PKT_CNT_W-1:0] PKT_CNT
`endif
);

   localparam int unsigned SELW = $clog2(NREQ);

   arb_state_t        state_q;
   logic [TIDW-1:0]   grant_q;
   logic [TIDW-1:0]   last_q;
   logic [NREQ-1:0]   grant_oh_q;

   logic [NREQ-1:0]   pick_oh;
   logic [TIDW-1:0]   pick_idx;
   logic              pick_any;

   logic              out_free;
   logic              accept;
   logic [SELW-1:0]   gsel;
   logic [TDATAW-1:0] sel_data;
   logic [TDESTW-1:0] sel_dest;
   logic              sel_last;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (TIDW)
   ) u_rr (
      .req     (AXIS_S_TVALID),
      .last    (last_q),
      .onehot  (pick_oh),
      .index   (pick_idx),
      .any_req (pick_any)
   );

   // Output stage can take a beat when empty or draining this cycle.
   assign out_free      = ~AXIS_M_TVALID | AXIS_M_TREADY;
   assign AXIS_S_TREADY = (state_q == BUSY && out_free) ? grant_oh_q : '0;
   assign accept        = |(AXIS_S_TVALID & AXIS_S_TREADY);

   assign gsel     = grant_q[SELW-1:0];
   assign sel_data = AXIS_S_TDATA[gsel*TDATAW +: TDATAW];
   assign sel_dest = AXIS_S_TDEST[gsel*TDESTW +: TDESTW];
   assign sel_last = AXIS_S_TLAST[gsel];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_oh_q    <= '0;
         last_q        <= TIDW'(NREQ - 1);
         AXIS_M_TVALID <= 1'b0;
         AXIS_M_TDATA  <= '0;
         AXIS_M_TLAST  <= 1'b0;
         AXIS_M_TDEST  <= '0;
         AXIS_M_TID    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_q    <= pick_idx;
                  grant_oh_q <= pick_oh;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (accept && sel_last) begin
                  last_q  <= grant_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (accept) begin
            AXIS_M_TVALID <= 1'b1;
            AXIS_M_TDATA  <= sel_data;
            AXIS_M_TLAST  <= sel_last;
            AXIS_M_TDEST  <= sel_dest;
            AXIS_M_TID    <= grant_q;
         end else if (AXIS_M_TREADY) begin
            AXIS_M_TVALID <= 1'b0;
         end
      end
   end

`ifdef NOC_ARB_PKT_CNT_EN
   for (genvar i = 0; i < NREQ; i++) begin : g_cnt
      logic [PKT_CNT_W-1:0] cnt_q;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            cnt_q <= '0;
         end else if (accept && sel_last && grant_oh_q[i]) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign PKT_CNT[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q;
   end
`else
   // Counterless build: arbitration and output stage are unchanged.
`endif

endmodule
